// File: rtl/cordic_vectoring_if.sv
// Handshake and data bus for the CORDIC vectoring block: input vector in,
// angle/magnitude result out.
interface cordic_vectoring_if #(
  parameter int DATA_WIDTH = 22
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH:0]   angle_out;
  logic        [DATA_WIDTH+1:0] magnitude_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, angle_out, magnitude_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, angle_out, magnitude_out
  );
endinterface

// File: rtl/cordic_vectoring.sv
// Iterative CORDIC in vectoring mode: one micro-rotation per enabled clock,
// returning atan2(y, x) and the gain-scaled magnitude.
module cordic_vectoring #(
  parameter int INTEGER_WIDTH        = 2,
  parameter int DECIMAL_WIDTH        = 20,
  parameter int DATA_WIDTH           = INTEGER_WIDTH + DECIMAL_WIDTH,
  parameter int CORDIC_COUNTER_WIDTH = 4,
  parameter int ITERATIONS           = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  cordic_vectoring_if.slave  bus
);

  localparam int W = DATA_WIDTH + 2;
  // Angle constants are Q.20 radians.
  localparam logic signed [W-1:0] HALF_PI = W'(1647099);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                          state;
  logic [CORDIC_COUNTER_WIDTH-1:0] cnt;
  logic signed [W-1:0]             x, y, z;
  logic                            zero;

  logic signed [W-1:0] xe, ye, x_sh, y_sh, atan_i, x_nx, y_nx, z_nx;
  logic                last;

  function automatic logic signed [W-1:0] atan_lut(input logic [CORDIC_COUNTER_WIDTH-1:0] i);
    case (int'(i))
      0:       return W'(823550);
      1:       return W'(486170);
      2:       return W'(256879);
      3:       return W'(130396);
      4:       return W'(65451);
      5:       return W'(32757);
      6:       return W'(16383);
      7:       return W'(8192);
      8:       return W'(4096);
      9:       return W'(2048);
      // Beyond i=9 atan(2^-i) rounds to exactly 2^(20-i).
      default: return W'(64'sd1048576 >>> i);
    endcase
  endfunction

  assign xe     = {{2{bus.x_in[DATA_WIDTH-1]}}, bus.x_in};
  assign ye     = {{2{bus.y_in[DATA_WIDTH-1]}}, bus.y_in};
  assign x_sh   = x >>> cnt;
  assign y_sh   = y >>> cnt;
  assign atan_i = atan_lut(cnt);
  assign last   = (cnt == CORDIC_COUNTER_WIDTH'(ITERATIONS - 1));

  always_comb begin
    x_nx = x;
    y_nx = y;
    z_nx = z;
    if (!y[W-1]) begin
      x_nx = x + y_sh;
      y_nx = y - x_sh;
      z_nx = z + atan_i;
    end else begin
      x_nx = x - y_sh;
      y_nx = y + x_sh;
      z_nx = z - atan_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      x                 <= '0;
      y                 <= '0;
      z                 <= '0;
      zero              <= 1'b0;
      bus.in_ready      <= 1'b1;
      bus.out_valid     <= 1'b0;
      bus.angle_out     <= '0;
      bus.magnitude_out <= '0;
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state        <= RUN;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            // A null vector would otherwise accumulate every atan step.
            zero         <= (bus.x_in == '0) && (bus.y_in == '0);
            if (!xe[W-1]) begin
              x <= xe;
              y <= ye;
              z <= '0;
            end else if (!ye[W-1]) begin
              x <= ye;
              y <= -xe;
              z <= HALF_PI;
            end else begin
              x <= -ye;
              y <= xe;
              z <= -HALF_PI;
            end
          end
        end
        RUN: begin
          x   <= x_nx;
          y   <= y_nx;
          z   <= z_nx;
          cnt <= cnt + 1'b1;
          if (last) begin
            state             <= DONE;
            bus.out_valid     <= 1'b1;
            bus.angle_out     <= zero ? '0 : z_nx[DATA_WIDTH:0];
            bus.magnitude_out <= x_nx;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
